ecc_secded_lockstep_chk: RTL and testbench
==========================================

Name: ecc_secded_lockstep_chk

Overview:
Registered, parametrised successor to the combinational dual-copy ECC fault detector.
- Runs two redundant SECDED decode copies on each valid codeword.
- Compares syndrome/mask/flags between copies and registers corrected data with a valid strobe.
- Keeps saturating error/fault counters and a three-state health FSM that degrades to failsafe pass-through after repeated lockstep mismatches.
- Sits on the read side of ECC-protected FIFO/RAM, between memory output and consumer.

Parameters:
- DATA_WIDTH, 16, data bits per codeword (4..64).
- PARITY_WIDTH, 6, SECDED check bits (extended Hamming); must satisfy 2^(PARITY_WIDTH-1) >= DATA_WIDTH+PARITY_WIDTH.
- CNT_WIDTH, 8, width of each event counter.
- FAULT_THRESH, 3, number of lockstep mismatches that forces FAILSAFE (1..2^CNT_WIDTH-1).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  data_in/parity_in valid this cycle.
- data_in  in  DATA_WIDTH  raw data from memory.
- parity_in  in  PARITY_WIDTH  stored check bits.
- bypass  in  1  pass data_in unchanged, no decode, no counting.
- detc_en  in  1  enables lockstep compare.
- inj_en  in  1  test: flip bit 0 of copy-1 mask before compare.
- clr  in  1  clear counters, sticky flags and FSM to NORMAL.
- out_valid  out  1  registered in_valid.
- data_out  out  DATA_WIDTH  corrected or raw data.
- sbit_err  out  1  single-bit error corrected (copy 0).
- dbit_err  out  1  double-bit error detected (copy 0).
- ecc_fault  out  1  lockstep mismatch on this beat, or FSM in FAILSAFE.
- fault_sticky  out  1  any mismatch since last rst/clr.
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH each  saturating event counts.
- health  out  2  FSM state: 0 NORMAL, 1 DEGRADED, 2 FAILSAFE.

Behaviour:
- Reset values: all outputs 0, health = NORMAL, data_out = 0.
- Latency: exactly 1 cycle. Outputs update only when in_valid = 1. When in_valid = 0, out_valid = 0 and data_out/flags hold their previous values. No backpressure.
- Per beat, combinational stage:
  - mismatch = detc_en & ~bypass & ({sbit,dbit,mask} of copy0 != copy1 after injection).
  - mismatch is forced 0 when bypass = 1 or detc_en = 0.
- data_out selection:
  - bypass = 1, mismatch, or FAILSAFE -> data_in.
  - otherwise -> data_in ^ mask0.
- sbit_err/dbit_err: copy-0 flags, forced 0 under bypass.
- ecc_fault = mismatch | (health == FAILSAFE).
- Counters increment by 1 on a valid beat with the respective event and saturate at all-ones; no wrap.
- FSM:
  - NORMAL -> DEGRADED on the first mismatch.
  - DEGRADED -> FAILSAFE when the mismatch count reaches FAULT_THRESH (compare uses the incremented value). With FAULT_THRESH = 1, NORMAL goes directly to FAILSAFE.
  - FAILSAFE is absorbing until clr or rst.
  - State changes take effect on the next beat's outputs.
- clr priority:
  - clr = 1 clears counters, sticky and FSM. Any same-cycle event is discarded.
  - Data path still produces output for a same-cycle valid beat.
- rst mid-stream: the in-flight beat is dropped (out_valid = 0 the next cycle).

Decomposition:
- Package ecc_pkg:
  - health_e enum (NORMAL/DEGRADED/FAILSAFE).
  - function parity_width(data_width).
  - function hamming_pos(i) mapping data bit to codeword position.
- Sub-module ecc_secded_cal: purely combinational generic SECDED encode/syndrome/mask, parametrised by DATA_WIDTH/PARITY_WIDTH, instantiated twice.
- Top holds registers, counters and FSM.

Test Plan:
- Clean codeword, data 0xA5A5 with correct parity, detc_en = 1 -> one cycle later out_valid = 1, data_out = 0xA5A5, all flags 0, counters 0.
- Flip data_in[3] on 0xA5A5 -> data_out = 0xA5A5, sbit_err = 1, sbit_cnt = 1. Flip bits 3 and 7 -> dbit_err = 1, data_out = raw 0xA52D.
- inj_en = 1 on 3 consecutive valid beats, FAULT_THRESH = 3:
  - beat 1: ecc_fault = 1, data_out = data_in, health = DEGRADED.
  - after beat 3: health = FAILSAFE; ecc_fault stays 1 on later clean beats with inj_en = 0.
- 300 single-bit-error beats, CNT_WIDTH = 8 -> sbit_cnt saturates at 255, no wrap.
- clr asserted on the same cycle as a mismatch beat -> next cycle fault_cnt = 0, fault_sticky = 0, health = NORMAL; out_valid = 1 for that beat.
- bypass = 1 with a corrupted codeword plus inj_en = 1 -> data_out = data_in, all flags and counters unchanged. rst mid-burst -> out_valid = 0 the next cycle, all outputs 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and elaboration-time helpers for the lockstep SECDED checker.
// The codeword uses extended Hamming layout: check bits at power-of-two positions, plus overall parity.
package ecc_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    FAILSAFE = 2'd2
  } health_e;

  // Smallest SECDED check-bit count for a data width: Hamming bits r with 2^r >= k+r+1, plus overall parity.
  function automatic int parity_width(input int data_width);
    int r;
    r = 0;
    for (int k = 15; k >= 1; k--) begin
      if ((1 << k) >= data_width + k + 1) r = k;
    end
    return r + 1;
  endfunction

  // Codeword position (1-based) of data bit i, skipping the power-of-two check-bit slots.
  function automatic int hamming_pos(input int i);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 3; p < 128; p++) begin
      if (((p & (p - 1)) != 0) && (pos == 0)) begin
        if (cnt == i) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_secded_cal.sv
// One combinational SECDED decode copy: re-encodes the data, forms the syndrome,
// and derives the single-bit correction mask plus single/double error flags.
module ecc_secded_cal
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PARITY_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [PARITY_WIDTH-1:0] parity_i,
  output logic [PARITY_WIDTH-2:0] syndrome_o,
  output logic [DATA_WIDTH-1:0]   mask_o,
  output logic                    sbit_o,
  output logic                    dbit_o
);

  localparam int R = PARITY_WIDTH - 1;

  logic [R-1:0] ham;
  logic         overall;
  int           pos;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ham = '0;
    pos = 0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pos = hamming_pos(i);
      for (int j = 0; j < R; j++) begin
        if (((pos >> j) & 1) != 0) ham[j] = ham[j] ^ data_i[i];
      end
    end

    syndrome_o = ham ^ parity_i[R-1:0];
    // Odd parity across the whole received word means an odd number of flips.
    overall    = ^{data_i, parity_i};
    sbit_o     = overall;
    dbit_o     = ~overall & (|syndrome_o);

    mask_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (overall && (int'(syndrome_o) == hamming_pos(i))) mask_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ecc_secded_lockstep_chk.sv
// Read-side ECC checker: two redundant SECDED decoders compared beat by beat, registered
// corrected data, saturating event counters and a NORMAL/DEGRADED/FAILSAFE health FSM.
module ecc_secded_lockstep_chk
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PARITY_WIDTH = parity_width(DATA_WIDTH),
  parameter int CNT_WIDTH    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [PARITY_WIDTH-1:0] parity_in,
  input  logic                    bypass,
  input  logic                    detc_en,
  input  logic                    inj_en,
  input  logic                    clr,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic [CNT_WIDTH-1:0]    fault_cnt,
  output logic [1:0]              health
);

  logic [PARITY_WIDTH-2:0] syn0, syn1;
  logic [DATA_WIDTH-1:0]   mask0, mask1, mask1_inj;
  logic                    sbit0, dbit0, sbit1, dbit1;
  logic                    mismatch, failsafe;
  logic [CNT_WIDTH-1:0]    fault_inc;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  sbit_err_q, sbit_err_d;
  logic                  dbit_err_q, dbit_err_d;
  logic                  ecc_fault_q, ecc_fault_d;
  logic                  fault_sticky_q, fault_sticky_d;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d;
  logic [CNT_WIDTH-1:0]  dbit_cnt_q, dbit_cnt_d;
  logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
  health_e               health_q, health_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  ecc_secded_cal #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_cal0 (
    .data_i    (data_in),
    .parity_i  (parity_in),
    .syndrome_o(syn0),
    .mask_o    (mask0),
    .sbit_o    (sbit0),
    .dbit_o    (dbit0)
  );

  ecc_secded_cal #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_cal1 (
    .data_i    (data_in),
    .parity_i  (parity_in),
    .syndrome_o(syn1),
    .mask_o    (mask1),
    .sbit_o    (sbit1),
    .dbit_o    (dbit1)
  );

  always_comb begin
    mask1_inj = mask1 ^ DATA_WIDTH'(inj_en);
    mismatch  = detc_en & ~bypass &
                ({syn0, sbit0, dbit0, mask0} != {syn1, sbit1, dbit1, mask1_inj});
    failsafe  = (health_q == FAILSAFE);
    fault_inc = sat_inc(fault_cnt_q);
  end

  always_comb begin
    out_valid_d    = in_valid;
    data_out_d     = data_out_q;
    sbit_err_d     = sbit_err_q;
    dbit_err_d     = dbit_err_q;
    ecc_fault_d    = ecc_fault_q;
    fault_sticky_d = fault_sticky_q;
    sbit_cnt_d     = sbit_cnt_q;
    dbit_cnt_d     = dbit_cnt_q;
    fault_cnt_d    = fault_cnt_q;
    health_d       = health_q;

    if (in_valid) begin
      // A copy disagreement means neither mask can be trusted, so forward raw data.
      data_out_d  = (bypass | mismatch | failsafe) ? data_in : (data_in ^ mask0);
      sbit_err_d  = sbit0 & ~bypass;
      dbit_err_d  = dbit0 & ~bypass;
      ecc_fault_d = mismatch | failsafe;

      if (sbit0 && !bypass) sbit_cnt_d = sat_inc(sbit_cnt_q);
      if (dbit0 && !bypass) dbit_cnt_d = sat_inc(dbit_cnt_q);
      if (mismatch) begin
        fault_cnt_d    = fault_inc;
        fault_sticky_d = 1'b1;
      end

      case (health_q)
        NORMAL: begin
          if (mismatch) begin
            health_d = (fault_inc >= CNT_WIDTH'(FAULT_THRESH)) ? FAILSAFE : DEGRADED;
          end
        end
        DEGRADED: begin
          if (mismatch && (fault_inc >= CNT_WIDTH'(FAULT_THRESH))) health_d = FAILSAFE;
        end
        default: health_d = FAILSAFE;
      endcase
    end

    // Clear wins over any same-cycle event; the data path above is unaffected.
    if (clr) begin
      fault_sticky_d = 1'b0;
      sbit_cnt_d     = '0;
      dbit_cnt_d     = '0;
      fault_cnt_d    = '0;
      health_d       = NORMAL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      data_out_q     <= '0;
      sbit_err_q     <= 1'b0;
      dbit_err_q     <= 1'b0;
      ecc_fault_q    <= 1'b0;
      fault_sticky_q <= 1'b0;
      sbit_cnt_q     <= '0;
      dbit_cnt_q     <= '0;
      fault_cnt_q    <= '0;
      health_q       <= NORMAL;
    end else begin
      out_valid_q    <= out_valid_d;
      data_out_q     <= data_out_d;
      sbit_err_q     <= sbit_err_d;
      dbit_err_q     <= dbit_err_d;
      ecc_fault_q    <= ecc_fault_d;
      fault_sticky_q <= fault_sticky_d;
      sbit_cnt_q     <= sbit_cnt_d;
      dbit_cnt_q     <= dbit_cnt_d;
      fault_cnt_q    <= fault_cnt_d;
      health_q       <= health_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign data_out     = data_out_q;
  assign sbit_err     = sbit_err_q;
  assign dbit_err     = dbit_err_q;
  assign ecc_fault    = ecc_fault_q;
  assign fault_sticky = fault_sticky_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign fault_cnt    = fault_cnt_q;
  assign health       = health_q;

endmodule

// File: tb/tb_ecc_secded_lockstep_chk.sv
// Directed bench for the lockstep SECDED checker; a second instance with FAULT_THRESH = 1
// shares the stimulus to cover the direct NORMAL -> FAILSAFE jump.
module tb_ecc_secded_lockstep_chk;

  // Hand-encoded codewords (extended Hamming, data bit i at the i-th non-power-of-two position).
  localparam logic [15:0] D_A5   = 16'hA5A5;
  localparam logic [5:0]  P_A5   = 6'h27;
  localparam logic [15:0] D_FF   = 16'hFFFF;
  localparam logic [5:0]  P_FF   = 6'h1E;
  localparam logic [15:0] D_A5_1 = 16'hA5AD;  // bit 3 flipped
  localparam logic [15:0] D_A5_2 = 16'hA52D;  // bits 3 and 7 flipped
  localparam logic [15:0] D_FF_1 = 16'h7FFF;  // bit 15 flipped

  logic        clk = 1'b0;
  logic        rst, in_valid, bypass, detc_en, inj_en, clr;
  logic [15:0] data_in;
  logic [5:0]  parity_in;

  logic        out_valid, sbit_err, dbit_err, ecc_fault, fault_sticky;
  logic [15:0] data_out;
  logic [7:0]  sbit_cnt, dbit_cnt, fault_cnt;
  logic [1:0]  health;

  logic        t1_out_valid, t1_sbit_err, t1_dbit_err, t1_ecc_fault, t1_fault_sticky;
  logic [15:0] t1_data_out;
  logic [7:0]  t1_sbit_cnt, t1_dbit_cnt, t1_fault_cnt;
  logic [1:0]  t1_health;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ecc_secded_lockstep_chk #(
    .DATA_WIDTH(16), .PARITY_WIDTH(6), .CNT_WIDTH(8), .FAULT_THRESH(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .parity_in(parity_in),
    .bypass(bypass), .detc_en(detc_en), .inj_en(inj_en), .clr(clr),
    .out_valid(out_valid), .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
    .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .health(health)
  );

  ecc_secded_lockstep_chk #(
    .DATA_WIDTH(16), .PARITY_WIDTH(6), .CNT_WIDTH(8), .FAULT_THRESH(1)
  ) dut_t1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .parity_in(parity_in),
    .bypass(bypass), .detc_en(detc_en), .inj_en(inj_en), .clr(clr),
    .out_valid(t1_out_valid), .data_out(t1_data_out), .sbit_err(t1_sbit_err),
    .dbit_err(t1_dbit_err), .ecc_fault(t1_ecc_fault), .fault_sticky(t1_fault_sticky),
    .sbit_cnt(t1_sbit_cnt), .dbit_cnt(t1_dbit_cnt), .fault_cnt(t1_fault_cnt),
    .health(t1_health)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, let it cross the edge, and land 1 ns after it for sampling.
  task automatic beat(input logic v, input logic [15:0] d, input logic [5:0] p);
    in_valid  = v;
    data_in   = d;
    parity_in = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; bypass = 1'b0; detc_en = 1'b1; inj_en = 1'b0; clr = 1'b0;
    data_in = '0; parity_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_flags", 32'({sbit_err, dbit_err, ecc_fault, fault_sticky}), 32'd0);
    check("rst_counts", 32'({sbit_cnt, dbit_cnt, fault_cnt}), 32'd0);
    check("rst_health", 32'(health), 32'd0);
    check("rst_t1_health", 32'(t1_health), 32'd0);
    rst = 1'b0;

    beat(1'b1, D_A5, P_A5);
    check("clean_valid", 32'(out_valid), 32'd1);
    check("clean_data", 32'(data_out), 32'hA5A5);
    check("clean_flags", 32'({sbit_err, dbit_err, ecc_fault, fault_sticky}), 32'd0);
    check("clean_counts", 32'({sbit_cnt, dbit_cnt, fault_cnt}), 32'd0);

    beat(1'b0, 16'h1234, 6'h00);
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_hold_data", 32'(data_out), 32'hA5A5);

    beat(1'b1, D_A5_1, P_A5);
    check("sbit3_data", 32'(data_out), 32'hA5A5);
    check("sbit3_flag", 32'(sbit_err), 32'd1);
    check("sbit3_cnt", 32'(sbit_cnt), 32'd1);

    beat(1'b1, D_FF, P_FF);
    check("ff_clean_data", 32'(data_out), 32'hFFFF);
    check("ff_clean_flags", 32'({sbit_err, dbit_err}), 32'd0);

    beat(1'b1, D_FF_1, P_FF);
    check("sbit15_data", 32'(data_out), 32'hFFFF);
    check("sbit15_cnt", 32'(sbit_cnt), 32'd2);

    beat(1'b1, D_A5, 6'h26);
    check("chkbit_data", 32'(data_out), 32'hA5A5);
    check("chkbit_flag", 32'(sbit_err), 32'd1);
    check("chkbit_cnt", 32'(sbit_cnt), 32'd3);

    beat(1'b1, D_A5_2, P_A5);
    check("dbit_data_raw", 32'(data_out), 32'hA52D);
    check("dbit_flags", 32'({sbit_err, dbit_err}), 32'b01);
    check("dbit_cnt", 32'(dbit_cnt), 32'd1);

    detc_en = 1'b0; inj_en = 1'b1;
    beat(1'b1, D_A5, P_A5);
    check("detc_off_fault", 32'(ecc_fault), 32'd0);
    check("detc_off_state", 32'({fault_cnt, health}), 32'd0);

    detc_en = 1'b1; bypass = 1'b1;
    beat(1'b1, D_A5_1, P_A5);
    check("bypass_valid", 32'(out_valid), 32'd1);
    check("bypass_data", 32'(data_out), 32'hA5AD);
    check("bypass_flags", 32'({sbit_err, dbit_err, ecc_fault, fault_sticky}), 32'd0);
    check("bypass_counts", 32'({sbit_cnt, dbit_cnt, fault_cnt}), {8'd0, 8'd3, 8'd1, 8'd0});
    check("bypass_t1_health", 32'(t1_health), 32'd0);

    bypass = 1'b0;
    beat(1'b1, D_A5_1, P_A5);
    check("inj1_fault", 32'(ecc_fault), 32'd1);
    check("inj1_data_raw", 32'(data_out), 32'hA5AD);
    check("inj1_health", 32'(health), 32'd1);
    check("inj1_fault_cnt", 32'(fault_cnt), 32'd1);
    check("inj1_sticky", 32'(fault_sticky), 32'd1);
    check("inj1_sbit_cnt", 32'(sbit_cnt), 32'd4);
    check("thresh1_health", 32'(t1_health), 32'd2);

    beat(1'b1, D_A5, P_A5);
    check("inj2_health", 32'(health), 32'd1);
    check("inj2_fault_cnt", 32'(fault_cnt), 32'd2);

    beat(1'b1, D_A5, P_A5);
    check("inj3_health", 32'(health), 32'd2);
    check("inj3_fault", 32'(ecc_fault), 32'd1);
    check("inj3_fault_cnt", 32'(fault_cnt), 32'd3);

    inj_en = 1'b0;
    beat(1'b1, D_A5_1, P_A5);
    check("failsafe_fault", 32'(ecc_fault), 32'd1);
    check("failsafe_data_raw", 32'(data_out), 32'hA5AD);
    check("failsafe_health", 32'(health), 32'd2);
    check("failsafe_fault_cnt", 32'(fault_cnt), 32'd3);

    clr = 1'b1; inj_en = 1'b1;
    beat(1'b1, D_A5, P_A5);
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_data", 32'(data_out), 32'hA5A5);
    check("clr_beat_fault", 32'(ecc_fault), 32'd1);
    check("clr_fault_cnt", 32'(fault_cnt), 32'd0);
    check("clr_sticky", 32'(fault_sticky), 32'd0);
    check("clr_health", 32'(health), 32'd0);
    check("clr_sbit_cnt", 32'(sbit_cnt), 32'd0);

    clr = 1'b0; inj_en = 1'b0;
    beat(1'b1, D_A5, P_A5);
    check("post_clr_fault", 32'(ecc_fault), 32'd0);
    check("post_clr_health", 32'(health), 32'd0);

    for (int i = 0; i < 254; i++) beat(1'b1, D_A5_1, P_A5);
    check("sat_254", 32'(sbit_cnt), 32'd254);
    beat(1'b1, D_A5_1, P_A5);
    check("sat_255", 32'(sbit_cnt), 32'd255);
    for (int i = 0; i < 45; i++) beat(1'b1, D_A5_1, P_A5);
    check("sat_no_wrap", 32'(sbit_cnt), 32'd255);

    rst = 1'b1;
    beat(1'b1, D_A5_1, P_A5);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_counts", 32'({sbit_cnt, dbit_cnt, fault_cnt}), 32'd0);
    check("midrst_flags", 32'({sbit_err, dbit_err, ecc_fault, fault_sticky, health}), 32'd0);

    rst = 1'b0;
    beat(1'b1, D_A5, P_A5);
    check("after_rst_valid", 32'(out_valid), 32'd1);
    check("after_rst_data", 32'(data_out), 32'hA5A5);

    in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
